branch_target_table: RTL and testbench
======================================

// Module: branch_target_table
// PURPOSE
//  Programmable, parametrised branch-target table for the fetch stage; supersedes the fixed
//  case-table target lookup. Maps a KEY_W-bit branch key to a PC_W-bit absolute target.
//  Entries are written at run time by the loader, carry a valid bit, and can be bulk-cleared
//  by a sequential sweep. Lookup is registered: 1-cycle latency with a hit/miss flag.
// PARAMETERS
//  KEY_W   5    key width; table depth DEPTH = 2**KEY_W
//  PC_W    12   target (program counter) width
//  CNT_W   16   width of the statistics counters (BTT_STATS_EN only)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  lookup_en    in   1      lookup request (the branch LUT enable)
//  key          in   KEY_W  lookup key
//  branch_pos   out  PC_W   registered target; valid the cycle after lookup_en
//  lookup_vld   out  1      registered; high the cycle after an accepted lookup
//  lookup_hit   out  1      registered; entry valid at lookup time
//  wr_en        in   1      program one entry
//  wr_key       in   KEY_W  entry index to program
//  wr_pos       in   PC_W   target value to store
//  clr_req      in   1      start bulk clear sweep (pulse)
//  busy         out  1      sweep in progress; lookups and writes ignored
//  hit_cnt      out  CNT_W  saturating count of hits (BTT_STATS_EN only)
//  miss_cnt     out  CNT_W  saturating count of misses (BTT_STATS_EN only)
// BEHAVIOUR
//  - Reset: all valid bits 0, all targets 0, state IDLE; branch_pos=0, lookup_vld=0,
//    lookup_hit=0, busy=0, hit_cnt=miss_cnt=0. Reset mid-sweep aborts sweep immediately.
//  - FSM: IDLE -> SWEEP on clr_req (IDLE only); SWEEP clears valid[idx] and target[idx] one
//    entry per cycle, idx 0..DEPTH-1; SWEEP -> IDLE after clearing DEPTH-1 (DEPTH cycles total).
//    busy is registered: high the cycle after clr_req is sampled, through the last clear cycle.
//    clr_req during SWEEP ignored (no restart).
//  - Lookup (IDLE only): at edge with lookup_en=1, lookup_vld<=1; lookup_hit<=valid[key];
//    branch_pos<=valid[key] ? target[key] : 0. lookup_en=0 -> lookup_vld<=0, branch_pos and
//    lookup_hit hold previous value.
//  - Lookup while busy: lookup_vld<=1, lookup_hit<=0, branch_pos<=0 (forced miss).
//  - Write (IDLE only): at edge with wr_en=1, target[wr_key]<=wr_pos, valid[wr_key]<=1.
//    Writes while busy are dropped. Rewriting a valid entry overwrites it.
//  - Same-cycle write and lookup of same key: write-first; lookup returns wr_pos, hit=1.
//  - Same-cycle clr_req and wr_en in IDLE: write is dropped, sweep starts.
//  - Same-cycle clr_req and lookup_en in IDLE: lookup served from pre-clear contents.
//  - No arithmetic on targets; stored and returned verbatim, zero-extended to nothing (PC_W exact).
// CONFIGURATION
//  BTT_STATS_EN defined: hit_cnt/miss_cnt increment on each accepted lookup (busy lookups
//  count as misses), saturate at 2**CNT_W-1, cleared by reset and by clr_req acceptance.
//  Not defined: counters not instantiated; hit_cnt and miss_cnt tied to 0.
// TESTING
//  1 Reset, lookup key=3 -> next cycle lookup_vld=1, lookup_hit=0, branch_pos=0.
//  2 Write key=2 pos=68, then lookup key=2 -> next cycle hit=1, branch_pos=68; idle cycle ->
//    lookup_vld=0, branch_pos stays 68.
//  3 Same cycle wr key=4 pos=55 and lookup key=4 -> next cycle hit=1, branch_pos=55.
//  4 Fill keys 0..31 with pos=key+100; clr_req -> busy high 32 cycles; write during sweep
//    dropped; lookup mid-sweep -> hit=0; after busy falls all keys miss.
//  5 Assert rst_n=0 at sweep cycle 10 -> busy=0 immediately; all entries invalid after release.
//  6 BTT_STATS_EN, CNT_W=2: 5 hits, 2 misses -> hit_cnt=3 (saturated), miss_cnt=2;
//    clr_req -> both 0. Without macro both read 0 throughout.

Source files
------------

// File: rtl/branch_target_table.sv
// Branch-target table for the fetch stage: maps a KEY_W-bit branch key to a PC_W-bit
// absolute target. Entries are programmed at run time, carry a valid bit, and can be
// bulk-cleared by a sequential sweep. Lookup is registered (1-cycle latency, hit flag).
// Optional hit/miss statistics counters are built when macro BTT_STATS_EN is defined;
// otherwise hit_cnt/miss_cnt are tied to zero.
module branch_target_table #(
   parameter int unsigned KEY_W = 5,
   parameter int unsigned PC_W  = 12,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lookup_en,
   input  logic [KEY_W-1:0] key,
   output logic [PC_W-1:0]  branch_pos,
   output logic             lookup_vld,
   output logic             lookup_hit,
   input  logic             wr_en,
   input  logic [KEY_W-1:0] wr_key,
   input  logic [PC_W-1:0]  wr_pos,
   input  logic             clr_req,
   output logic             busy,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int unsigned DEPTH = 2 ** KEY_W;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   state_t                      r_state;
   logic [KEY_W-1:0]            r_idx;
   logic                        r_busy;
   logic [DEPTH-1:0]            r_valid;
   logic [DEPTH-1:0][PC_W-1:0]  r_target;
   logic [PC_W-1:0]             r_pos;
   logic                        r_vld;
   logic                        r_hit;

   logic                        w_idle;
   logic                        w_clr_acc;
   logic                        w_wr_acc;
   logic                        w_hit;
   logic [PC_W-1:0]             w_pos;

   // A clear request only takes effect in IDLE and wins over a same-cycle write
   assign w_idle    = (r_state == ST_IDLE);
   assign w_clr_acc = w_idle & clr_req;
   assign w_wr_acc  = w_idle & wr_en & ~clr_req;

   // Sweep sequencer: walks idx 0..DEPTH-1, one entry per cycle; busy mirrors SWEEP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (clr_req) begin
                  r_state <= ST_SWEEP;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_SWEEP: begin
               if (r_idx == KEY_W'(DEPTH - 1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx <= r_idx + KEY_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Table storage: sweep clears one entry per cycle, otherwise accepted writes program
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= '0;
         r_target <= '0;
      end else if (r_state == ST_SWEEP) begin
         r_valid[r_idx]  <= 1'b0;
         r_target[r_idx] <= '0;
      end else if (w_wr_acc) begin
         r_valid[wr_key]  <= 1'b1;
         r_target[wr_key] <= wr_pos;
      end
   end

   // Lookup result: forced miss while sweeping, write-first bypass on a same-key write
   always_comb begin
      w_hit = 1'b0;
      w_pos = '0;
      if (!w_idle) begin
         w_hit = 1'b0;
         w_pos = '0;
      end else if (w_wr_acc && (wr_key == key)) begin
         w_hit = 1'b1;
         w_pos = wr_pos;
      end else if (r_valid[key]) begin
         w_hit = 1'b1;
         w_pos = r_target[key];
      end
   end

   // Registered lookup outputs; hit/pos hold when no lookup is requested
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= 1'b0;
         r_hit <= 1'b0;
         r_pos <= '0;
      end else if (lookup_en) begin
         r_vld <= 1'b1;
         r_hit <= w_hit;
         r_pos <= w_pos;
      end else begin
         r_vld <= 1'b0;
      end
   end

   assign branch_pos = r_pos;
   assign lookup_vld = r_vld;
   assign lookup_hit = r_hit;
   assign busy       = r_busy;

`ifdef BTT_STATS_EN
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_miss_cnt;

   // Saturating hit/miss statistics; an accepted clear request zeroes both
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_clr_acc) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (lookup_en) begin
         if (w_hit) begin
            if (r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
         end else begin
            if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_target_table.sv
// Self-checking bench for branch_target_table: directed scenarios followed by random
// traffic, every cycle compared against a behavioural table model.
module tb_branch_target_table;

   localparam int unsigned KEY_W = 5;
   localparam int unsigned PC_W  = 12;
   localparam int unsigned CNT_W = 2;
   localparam int          DEPTH = 1 << KEY_W;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             lookup_en;
   logic [KEY_W-1:0] key;
   logic [PC_W-1:0]  branch_pos;
   logic             lookup_vld;
   logic             lookup_hit;
   logic             wr_en;
   logic [KEY_W-1:0] wr_key;
   logic [PC_W-1:0]  wr_pos;
   logic             clr_req;
   logic             busy;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;

   branch_target_table #(.KEY_W(KEY_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .lookup_en(lookup_en), .key(key),
      .branch_pos(branch_pos), .lookup_vld(lookup_vld), .lookup_hit(lookup_hit),
      .wr_en(wr_en), .wr_key(wr_key), .wr_pos(wr_pos), .clr_req(clr_req),
      .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: table contents, remaining sweep cycles, expected outputs
   bit  m_valid [DEPTH];
   int  m_tgt   [DEPTH];
   int  m_sweep_left;
   bit  m_vld, m_hit;
   int  m_pos, m_hc, m_mc;
   int  errors = 0;
   int  checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0;
         m_tgt[i]   = 0;
      end
      m_sweep_left = 0;
      m_vld = 1'b0; m_hit = 1'b0; m_pos = 0; m_hc = 0; m_mc = 0;
   endtask

   task automatic check_all(input string tag);
      int ehc, emc;
`ifdef BTT_STATS_EN
      ehc = m_hc; emc = m_mc;
`else
      ehc = 0; emc = 0;
`endif
      check({tag, ".vld"},  32'(lookup_vld), 32'(m_vld));
      check({tag, ".hit"},  32'(lookup_hit), 32'(m_hit));
      check({tag, ".pos"},  32'(branch_pos), m_pos);
      check({tag, ".busy"}, 32'(busy),       32'(m_sweep_left > 0));
      check({tag, ".hcnt"}, 32'(hit_cnt),    ehc);
      check({tag, ".mcnt"}, 32'(miss_cnt),   emc);
   endtask

   // One clock: drive inputs, advance the model by the table rules, compare after the edge
   task automatic cycle(input string tag, input bit lk, input int k, input bit we,
                        input int wk, input int wp, input bit clr);
      bit sweeping;
      k  = k % DEPTH;
      wk = wk % DEPTH;
      wp = wp % (1 << PC_W);
      lookup_en = lk; key = KEY_W'(k);
      wr_en = we; wr_key = KEY_W'(wk); wr_pos = PC_W'(wp); clr_req = clr;

      sweeping = (m_sweep_left > 0);
      if (lk) begin
         m_vld = 1'b1;
         if (sweeping) begin
            m_hit = 1'b0; m_pos = 0;
         end else if (we && !clr && wk == k) begin
            m_hit = 1'b1; m_pos = wp;
         end else begin
            m_hit = m_valid[k];
            m_pos = m_valid[k] ? m_tgt[k] : 0;
         end
      end else begin
         m_vld = 1'b0;
      end

      if (!sweeping && clr) begin
         m_hc = 0; m_mc = 0;
      end else if (lk) begin
         if (m_hit) m_hc = (m_hc < CMAX) ? m_hc + 1 : CMAX;
         else       m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
      end

      if (sweeping) begin
         m_valid[DEPTH - m_sweep_left] = 1'b0;
         m_tgt[DEPTH - m_sweep_left]   = 0;
         m_sweep_left--;
      end else if (clr) begin
         m_sweep_left = DEPTH;
      end else if (we) begin
         m_valid[wk] = 1'b1;
         m_tgt[wk]   = wp;
      end

      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 0, 1'b0, 0, 0, 1'b0);
   endtask

   // Asynchronous reset pulse with an immediate check of the cleared outputs
   task automatic pulse_reset(input string tag);
      lookup_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      lookup_en = 1'b0; key = '0; wr_en = 1'b0; wr_key = '0; wr_pos = '0; clr_req = 1'b0;
      model_reset();
      #3;
      check_all("reset");
      #4;
      rst_n = 1'b1;

      // 1: lookup on empty table misses
      cycle("t1_lookup3", 1'b1, 3, 1'b0, 0, 0, 1'b0);
      check("t1_pos_const", 32'(branch_pos), 0);

      // 2: write then lookup, then idle holds the target
      cycle("t2_wr",     1'b0, 0, 1'b1, 2, 68, 1'b0);
      cycle("t2_lookup", 1'b1, 2, 1'b0, 0, 0,  1'b0);
      check("t2_pos_const", 32'(branch_pos), 68);
      idle("t2_idle");
      check("t2_hold_const", 32'(branch_pos), 68);

      // 3: same-cycle write and lookup of the same key returns the new value
      cycle("t3_bypass", 1'b1, 4, 1'b1, 4, 55, 1'b0);
      check("t3_pos_const", 32'(branch_pos), 55);

      // 4: fill, sweep with a dropped write and a mid-sweep lookup, then all keys miss
      for (int i = 0; i < DEPTH; i++) cycle("t4_fill", 1'b0, 0, 1'b1, i, i + 100, 1'b0);
      cycle("t4_look7", 1'b1, 7, 1'b0, 0, 0, 1'b0);
      cycle("t4_clr", 1'b1, 9, 1'b1, 11, 999, 1'b1);
      check("t4_preclear_pos", 32'(branch_pos), 109);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 5)       cycle("t4_sweep_wr", 1'b0, 0, 1'b1, 30, 77, 1'b0);
         else if (i == 12) cycle("t4_sweep_lk", 1'b1, 31, 1'b0, 0, 0, 1'b0);
         else if (i == 20) cycle("t4_sweep_clr", 1'b0, 0, 1'b0, 0, 0, 1'b1);
         else              idle("t4_sweep");
      end
      for (int i = 0; i < DEPTH; i++) cycle("t4_after", 1'b1, i, 1'b0, 0, 0, 1'b0);

      // 5: reset during sweep aborts it
      for (int i = 0; i < 8; i++) cycle("t5_fill", 1'b0, 0, 1'b1, i * 3, i * 17 + 1, 1'b0);
      cycle("t5_clr", 1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 9; i++) idle("t5_sweep");
      pulse_reset("t5_rst");
      for (int i = 0; i < DEPTH; i++) cycle("t5_after", 1'b1, i, 1'b0, 0, 0, 1'b0);

      // 6: counter saturation and clear
      pulse_reset("t6_rst");
      cycle("t6_wr", 1'b0, 0, 1'b1, 6, 321, 1'b0);
      for (int i = 0; i < 5; i++) cycle("t6_hit", 1'b1, 6, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 2; i++) cycle("t6_miss", 1'b1, 8, 1'b0, 0, 0, 1'b0);
`ifdef BTT_STATS_EN
      check("t6_hcnt_const", 32'(hit_cnt), 3);
      check("t6_mcnt_const", 32'(miss_cnt), 2);
`else
      check("t6_hcnt_const", 32'(hit_cnt), 0);
      check("t6_mcnt_const", 32'(miss_cnt), 0);
`endif
      cycle("t6_clr", 1'b0, 0, 1'b0, 0, 0, 1'b1);
      check("t6_hcnt_clr", 32'(hit_cnt), 0);
      check("t6_mcnt_clr", 32'(miss_cnt), 0);
      for (int i = 0; i < DEPTH; i++) idle("t6_sweep");

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         cycle("rand",
               1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(0, (1 << PC_W) - 1)),
               ($urandom_range(0, 39) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
